l2_instr_responder: RTL and testbench
=====================================

L2_INSTR_RESPONDER -- requirements
Module: l2_instr_responder

Interface
REQ-001 Parameter MEM_DEPTH_LOG2, default 10: log2 of word count in backing array.
REQ-002 Parameter LATENCY, default 2: extra cycles between address capture and data drive (legal 0..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 Com_Bus_Gnt  input  1  OR of all arbiter grants on the instruction common bus.
REQ-006 Address_Com  inout  32  common address bus; sampled only, never driven by this block.
REQ-007 Data_Bus_Com  inout  32  common data bus; driven only in DRIVE, else Z.
REQ-008 Data_in_Bus  inout  1  data-valid strobe; driven 1 in DRIVE, else Z.
REQ-009 Mem_Wr  input  1  preload write enable.
REQ-010 Mem_Wr_Addr  input  MEM_DEPTH_LOG2  preload word address.
REQ-011 Mem_Wr_Data  input  32  preload data.
REQ-012 Resp_busy  output  1  high in any state other than IDLE.
REQ-013 Resp_count  output  16  count of completed responses.

Function
REQ-014 The block SHALL implement FSM states IDLE, ADDR, WAIT, DRIVE.
REQ-015 IDLE: Gnt=1 sampled -> ADDR; else stay.
REQ-016 ADDR: one cycle to let the granted requester drive Address_Com; Gnt=1 sampled -> capture word index Address_Com[MEM_DEPTH_LOG2+1:2] and array data at that index, load counter with LATENCY; go to DRIVE if LATENCY=0, else WAIT.
REQ-017 Address bits [1:0] and bits above MEM_DEPTH_LOG2+1 SHALL be ignored (addresses alias modulo depth).
REQ-018 WAIT: counter decrements each cycle; transition to DRIVE on the edge where the counter reaches 0.
REQ-019 Latency: Data_in_Bus=1 first visible LATENCY+1 cycles after the ADDR capture edge (LATENCY=0 -> the cycle immediately after capture).
REQ-020 DRIVE: Data_Bus_Com = captured data, Data_in_Bus = 1, held while Gnt=1; Gnt=0 sampled -> IDLE, buses Z from the next cycle, Resp_count increments by 1.
REQ-021 Resp_count SHALL wrap from 16'hFFFF to 0.
REQ-022 Gnt=0 sampled in ADDR or WAIT -> abort to IDLE; no drive; Resp_count unchanged.
REQ-023 Mem_Wr=1 SHALL write the array on that edge in any state; a write to the index captured on the same edge returns the old data (read-before-write); later writes do not alter captured data.
REQ-024 Outside DRIVE, Data_Bus_Com and Data_in_Bus SHALL be high-impedance; Address_Com is never driven.
REQ-025 Only one request is serviced at a time; Gnt activity while in DRIVE does not start a new transaction until IDLE is re-entered.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, counter 0, Resp_busy 0, Resp_count 0, Data_Bus_Com and Data_in_Bus Z, in any state including mid-WAIT or DRIVE.
REQ-027 Reset SHALL NOT clear the backing array; rst has priority over all other inputs including Mem_Wr.

Verification
REQ-028 Preload word 5 = 32'hDEADBEEF; grant, Address_Com=32'h14, LATENCY=2 -> Data_in_Bus=1 and Data_Bus_Com=32'hDEADBEEF three cycles after capture; drop Gnt -> Z next cycle, Resp_count=1.
REQ-029 LATENCY=0, address 32'h0 with word 0 = 32'h1 -> Data_in_Bus=1 the cycle after capture.
REQ-030 Gnt dropped during WAIT -> return to IDLE, Data_in_Bus stays Z, Resp_count unchanged.
REQ-031 Same-edge capture of index 3 and Mem_Wr to index 3 with 32'hAAAA0000 (old 32'h12345678) -> response 32'h12345678; the next request returns 32'hAAAA0000.
REQ-032 rst asserted in DRIVE -> next cycle buses Z, Resp_busy=0, Resp_count=0; array contents retained.
REQ-033 Address 32'h1014 with MEM_DEPTH_LOG2=10 -> returns word 5 (alias).

Source files
------------

// File: rtl/l2_instr_responder.sv
// rtl/l2_instr_responder.sv - instruction-bus L2 responder with fixed-latency read response
module l2_instr_responder #(
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int LATENCY        = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      Com_Bus_Gnt,
  inout  wire logic [31:0]          Address_Com,
  inout  wire logic [31:0]          Data_Bus_Com,
  inout  wire logic                 Data_in_Bus,
  input  logic                      Mem_Wr,
  input  logic [MEM_DEPTH_LOG2-1:0] Mem_Wr_Addr,
  input  logic [31:0]               Mem_Wr_Data,
  output logic                      Resp_busy,
  output logic [15:0]               Resp_count
);

  localparam int         DEPTH = 1 << MEM_DEPTH_LOG2;
  localparam logic [3:0] LAT4  = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, DRIVE} state_t;

  state_t                    state;
  state_t                    state_next;
  logic [31:0]               mem [DEPTH];
  logic [MEM_DEPTH_LOG2-1:0] rd_idx;
  logic [31:0]               rd_data;
  logic [3:0]                lat_cnt;
  logic                      capture;
  logic                      drive_en;
  logic                      unused_addr_bits;

  // Byte-offset bits and bits above the array size are don't-care: addresses alias modulo depth.
  assign rd_idx           = Address_Com[MEM_DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^{Address_Com[31:MEM_DEPTH_LOG2+2], Address_Com[1:0]};
  assign capture          = (state == ADDR) && Com_Bus_Gnt;

  // State register; reset returns to IDLE from anywhere.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: a dropped grant before or during the drive phase always returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Com_Bus_Gnt) state_next = ADDR;
      ADDR: begin
        if (!Com_Bus_Gnt)       state_next = IDLE;
        else if (LAT4 == 4'd0)  state_next = DRIVE;
        else                    state_next = WAIT;
      end
      WAIT: begin
        if (!Com_Bus_Gnt)          state_next = IDLE;
        else if (lat_cnt <= 4'd1)  state_next = DRIVE;
      end
      DRIVE:   if (!Com_Bus_Gnt) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state only; the buses are released whenever we are not driving.
  always_comb begin
    Resp_busy = (state != IDLE);
    drive_en  = (state == DRIVE);
  end

  assign Data_Bus_Com = drive_en ? rd_data : 'z;
  assign Data_in_Bus  = drive_en ? 1'b1    : 1'bz;

  // Datapath: capture word and latency on the ADDR edge, count down in WAIT, count completions.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt    <= '0;
      rd_data    <= '0;
      Resp_count <= '0;
    end else begin
      if (capture) begin
        rd_data <= mem[rd_idx];
        lat_cnt <= LAT4;
      end else if (state == WAIT && lat_cnt != 4'd0) begin
        lat_cnt <= lat_cnt - 4'd1;
      end
      if (state == DRIVE && !Com_Bus_Gnt) Resp_count <= Resp_count + 16'd1;
    end
  end

  // Preload port; the capture above reads the pre-write value on a same-edge collision.
  always_ff @(posedge clk) begin
    if (!rst && Mem_Wr) mem[Mem_Wr_Addr] <= Mem_Wr_Data;
  end

endmodule

// File: tb/tb_l2_instr_responder.sv
// tb/tb_l2_instr_responder.sv - bench for l2_instr_responder at LATENCY 2 and 0
module tb_l2_instr_responder;

  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst, gnt, wr;
  logic [AW-1:0] wr_addr;
  logic [31:0] wr_data, addr_com;
  wire  [31:0] Address_Com;
  wire  [31:0] db2, db0;
  wire         s2, s0;
  logic        busy2, busy0;
  logic [15:0] cnt2, cnt0;

  assign Address_Com = addr_com;

  always #5 clk = ~clk;

  l2_instr_responder #(.MEM_DEPTH_LOG2(AW), .LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst), .Com_Bus_Gnt(gnt), .Address_Com(Address_Com),
    .Data_Bus_Com(db2), .Data_in_Bus(s2), .Mem_Wr(wr), .Mem_Wr_Addr(wr_addr),
    .Mem_Wr_Data(wr_data), .Resp_busy(busy2), .Resp_count(cnt2)
  );

  l2_instr_responder #(.MEM_DEPTH_LOG2(AW), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .Com_Bus_Gnt(gnt), .Address_Com(Address_Com),
    .Data_Bus_Com(db0), .Data_in_Bus(s0), .Mem_Wr(wr), .Mem_Wr_Addr(wr_addr),
    .Mem_Wr_Data(wr_data), .Resp_busy(busy0), .Resp_count(cnt0)
  );

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Transaction model: index 0 is the LATENCY=2 instance, index 1 the LATENCY=0 instance.
  logic [31:0] mem_m [1<<AW];
  bit          m_busy [2] = '{1'b0, 1'b0};
  int          m_age  [2] = '{0, 0};
  logic [15:0] m_cnt  [2] = '{16'd0, 16'd0};
  logic [31:0] m_data [2] = '{32'd0, 32'd0};

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  // age counts granted edges since the transaction began; capture is at age 1,
  // and the response is on the bus once LATENCY further edges have passed.
  function automatic bit m_drv(input int k);
    return m_busy[k] && (m_age[k] >= 1 + lat_of(k));
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_busy[k] = 1'b0;
        m_age[k]  = 0;
        m_cnt[k]  = 16'd0;
      end else if (!m_busy[k]) begin
        if (gnt) begin
          m_busy[k] = 1'b1;
          m_age[k]  = 0;
        end
      end else if (!gnt) begin
        if (m_drv(k)) m_cnt[k] = m_cnt[k] + 16'd1;
        m_busy[k] = 1'b0;
      end else begin
        m_age[k] = m_age[k] + 1;
        if (m_age[k] == 1) m_data[k] = mem_m[addr_com[AW+1:2]];
      end
    end
    if (!rst && wr) mem_m[wr_addr] = wr_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_off(input string name, input logic [31:0] data, input logic strobe);
    checks++;
    if (!((data === 32'b0 || data === 32'bz) && (strobe === 1'b0 || strobe === 1'bz))) begin
      errors++;
      $display("FAIL %s actual data=%h strobe=%b required released bus", name, data, strobe);
    end
  endtask

  task automatic chk_bus(input string name, input logic [31:0] data, input logic strobe,
                         input bit drv, input logic [31:0] exp);
    if (drv) begin
      chk({name, "_strobe"}, 32'(strobe), 32'd1);
      chk({name, "_data"}, data, exp);
    end else begin
      chk_off({name, "_off"}, data, strobe);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("busy_l2", 32'(busy2), 32'(m_busy[0]));
      chk("busy_l0", 32'(busy0), 32'(m_busy[1]));
      chk("count_l2", 32'(cnt2), 32'(m_cnt[0]));
      chk("count_l0", 32'(cnt0), 32'(m_cnt[1]));
      chk_bus("bus_l2", db2, s2, m_drv(0), m_data[0]);
      chk_bus("bus_l0", db0, s0, m_drv(1), m_data[1]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    wr = 1'b1; wr_addr = a; wr_data = d;
    tick(1);
    wr = 1'b0;
  endtask

  initial begin
    int hold;
    hold = 0;
    rst = 1'b1; gnt = 1'b0; wr = 1'b0; wr_addr = '0; wr_data = '0; addr_com = '0;
    tick(3);
    chk("rst_busy", 32'(busy2), 32'd0);
    chk("rst_count", 32'(cnt2), 32'd0);
    chk_off("rst_bus", db2, s2);
    check_en = 1'b1;
    rst = 1'b0;

    for (int i = 0; i < (1 << AW); i++) preload(AW'(i), $urandom);
    preload(AW'(5), 32'hDEADBEEF);
    preload(AW'(0), 32'h00000001);
    preload(AW'(3), 32'h12345678);

    // Word 5 via 0x14: LATENCY=0 drives right after capture, LATENCY=2 three cycles after.
    gnt = 1'b1; addr_com = 32'h14;
    tick(2);
    chk("a_l0_data", db0, 32'hDEADBEEF);
    chk_off("a_l2_early", db2, s2);
    tick(1);
    chk_off("a_l2_wait", db2, s2);
    tick(1);
    chk("a_l2_strobe", 32'(s2), 32'd1);
    chk("a_l2_data", db2, 32'hDEADBEEF);
    gnt = 1'b0;
    tick(1);
    chk_off("a_l2_release", db2, s2);
    chk("a_l2_count", 32'(cnt2), 32'd1);

    // Word 0 with a short grant: the LATENCY=2 instance aborts in WAIT.
    gnt = 1'b1; addr_com = 32'h0;
    tick(2);
    chk("b_l0_data", db0, 32'h00000001);
    chk("b_l0_strobe", 32'(s0), 32'd1);
    gnt = 1'b0;
    tick(1);
    chk_off("b_l2_abort", db2, s2);
    chk("b_l2_count", 32'(cnt2), 32'd1);
    chk("b_l0_count", 32'(cnt0), 32'd2);

    // Same-edge capture and write of index 3 returns the old word.
    gnt = 1'b1; addr_com = 32'hC;
    tick(1);
    wr = 1'b1; wr_addr = AW'(3); wr_data = 32'hAAAA0000;
    tick(1);
    wr = 1'b0;
    tick(2);
    chk("c_l2_old", db2, 32'h12345678);
    chk("c_l0_old", db0, 32'h12345678);
    gnt = 1'b0;
    tick(1);
    gnt = 1'b1;
    tick(4);
    chk("c_l2_new", db2, 32'hAAAA0000);
    gnt = 1'b0;
    tick(1);
    chk("c_l2_count", 32'(cnt2), 32'd3);

    // Aliased address 0x1014 reads word 5.
    gnt = 1'b1; addr_com = 32'h1014;
    tick(4);
    chk("d_alias", db2, 32'hDEADBEEF);
    gnt = 1'b0;
    tick(1);

    // Reset while driving; array contents survive.
    gnt = 1'b1; addr_com = 32'h14;
    tick(4);
    rst = 1'b1;
    tick(1);
    chk("e_busy", 32'(busy2), 32'd0);
    chk("e_count", 32'(cnt2), 32'd0);
    chk_off("e_bus", db2, s2);
    rst = 1'b0; gnt = 1'b0;
    tick(1);
    gnt = 1'b1;
    tick(4);
    chk("e_retained", db2, 32'hDEADBEEF);
    gnt = 1'b0;
    tick(1);
    chk("e_count_after", 32'(cnt2), 32'd1);

    // Randomised traffic with colliding writes and occasional reset.
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        gnt  = ($urandom_range(0, 3) != 0);
        hold = $urandom_range(1, 8);
      end
      hold--;
      addr_com = $urandom;
      wr       = ($urandom_range(0, 3) == 0);
      wr_addr  = ($urandom_range(0, 1) == 0) ? addr_com[AW+1:2] : AW'($urandom);
      wr_data  = $urandom;
      rst      = ($urandom_range(0, 299) == 0);
      tick(1);
    end
    rst = 1'b0; gnt = 1'b0; wr = 1'b0;
    tick(2);
    check_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
